// File: rtl/sc_mmio_ports.sv
// Memory-mapped I/O port block: N_OUT output registers, N_IN synchronised inputs, sticky change flags.
// Define SC_MMIO_IRQ_EN to add the MASK register and the registered irq output.
module sc_mmio_ports #(
  parameter int          DATA_W  = 32,
  parameter int          N_IN    = 2,
  parameter int          N_OUT   = 2,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      we,
  output logic                      io_hit,
  output logic [DATA_W-1:0]         rdata,
  output logic [N_OUT*DATA_W-1:0]   out_port,
  input  logic [N_IN*DATA_W-1:0]    in_port
`ifdef SC_MMIO_IRQ_EN
  ,
  output logic                      irq
`endif
);

  if (DATA_W < N_IN || N_IN < 1 || N_IN > 16 || N_OUT < 1 || N_OUT > 16) begin : g_bad_cfg
    $error("sc_mmio_ports: illegal parameters (need 1<=N_IN<=16, 1<=N_OUT<=16, DATA_W>=N_IN)");
  end

  localparam logic [5:0] OFF_FLAGS = 6'd32;
  localparam logic [5:0] OFF_MASK  = 6'd33;

  logic [5:0]        off;
  logic              wr;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] out_q [N_OUT];
  logic [DATA_W-1:0] out_d [N_OUT];
  logic [DATA_W-1:0] s1_q  [N_IN];
  logic [DATA_W-1:0] s2_q  [N_IN];
  logic [DATA_W-1:0] s3_q  [N_IN];
  logic [N_IN-1:0]   flags_q;
  logic [N_IN-1:0]   flags_d;

  assign io_hit           = (addr[31:8] == IO_BASE[31:8]);
  assign off              = addr[7:2];
  assign wr               = we & io_hit;
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      out_d[k] = (wr && off == 6'(k)) ? wdata : out_q[k];
    end
    // A change detected on this edge outranks a W1C of the same bit.
    for (int k = 0; k < N_IN; k++) begin
      flags_d[k] = (flags_q[k] & ~(wr && off == OFF_FLAGS && wdata[k])) | (s2_q[k] != s3_q[k]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      flags_q <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
      flags_q <= flags_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out_port[gi*DATA_W +: DATA_W] = out_q[gi];
  end

  for (gi = 0; gi < N_IN; gi++) begin : g_in
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        s1_q[gi] <= '0;
        s2_q[gi] <= '0;
        s3_q[gi] <= '0;
      end else begin
        s1_q[gi] <= in_port[gi*DATA_W +: DATA_W];
        s2_q[gi] <= s1_q[gi];
        s3_q[gi] <= s2_q[gi];
      end
    end
  end

`ifdef SC_MMIO_IRQ_EN
  logic [N_IN-1:0] mask_q;
  logic [N_IN-1:0] mask_d;
  logic            irq_q;
  logic            irq_d;

  // irq trails the flag register by one edge, both on assert and on W1C release.
  always_comb begin
    mask_d = (wr && off == OFF_MASK) ? wdata[N_IN-1:0] : mask_q;
    irq_d  = |(flags_q & mask_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    if (io_hit) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (off == 6'(k)) rdata = out_q[k];
      end
      for (int k = 0; k < N_IN; k++) begin
        if (off == 6'(16 + k)) rdata = s2_q[k];
      end
      if (off == OFF_FLAGS) rdata = DATA_W'(flags_q);
`ifdef SC_MMIO_IRQ_EN
      if (off == OFF_MASK) rdata = DATA_W'(mask_q);
`endif
    end
  end

endmodule

// File: tb/tb_sc_mmio_ports.sv
// Directed bench for sc_mmio_ports (default parameters); irq checks run only when SC_MMIO_IRQ_EN is defined.
module tb_sc_mmio_ports;

  logic        clock;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        io_hit;
  logic [31:0] rdata;
  logic [63:0] out_port;
  logic [63:0] in_port;
`ifdef SC_MMIO_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sc_mmio_ports dut (
    .clock    (clock),
    .resetn   (resetn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .io_hit   (io_hit),
    .rdata    (rdata),
    .out_port (out_port),
    .in_port  (in_port)
`ifdef SC_MMIO_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic [63:0] exp_out;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d,
                              logic [31:0] er, logic eh, logic [63:0] eo);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_hit = eh; v.exp_out = eo;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] exp, string name);
    we = 1'b0;
    addr = a;
    #1;
    check(name, 64'(rdata), 64'(exp));
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
  endtask

  localparam logic [31:0] MASK_RB =
`ifdef SC_MMIO_IRQ_EN
    32'h3;
`else
    32'h0;
`endif

  initial begin
    vecs[0]  = mk(1, 32'hFFFF_FF04, 32'h0000_1234, 32'h0,         1, 64'h0);
    vecs[1]  = mk(0, 32'hFFFF_FF04, 32'h0,         32'h0000_1234, 1, 64'h0000_1234_0000_0000);
    vecs[2]  = mk(1, 32'hFFFF_FF00, 32'hCAFE_0001, 32'h0,         1, 64'h0000_1234_0000_0000);
    vecs[3]  = mk(0, 32'hFFFF_FF00, 32'h0,         32'hCAFE_0001, 1, 64'h0000_1234_CAFE_0001);
    vecs[4]  = mk(0, 32'hFFFF_FF02, 32'h0,         32'hCAFE_0001, 1, 64'h0000_1234_CAFE_0001);
    vecs[5]  = mk(1, 32'h0000_0010, 32'h0000_DEAD, 32'h0,         0, 64'h0000_1234_CAFE_0001);
    vecs[6]  = mk(0, 32'hFFFF_FF04, 32'h0,         32'h0000_1234, 1, 64'h0000_1234_CAFE_0001);
    vecs[7]  = mk(1, 32'hFFFF_FF3C, 32'h0000_5555, 32'h0,         1, 64'h0000_1234_CAFE_0001);
    vecs[8]  = mk(0, 32'hFFFF_FF3C, 32'h0,         32'h0,         1, 64'h0000_1234_CAFE_0001);
    vecs[9]  = mk(1, 32'hFFFF_FF40, 32'h0000_7777, 32'h0,         1, 64'h0000_1234_CAFE_0001);
    vecs[10] = mk(0, 32'hFFFF_FF40, 32'h0,         32'h0,         1, 64'h0000_1234_CAFE_0001);
    vecs[11] = mk(1, 32'hFFFF_FF84, 32'h0000_0003, 32'h0,         1, 64'h0000_1234_CAFE_0001);
    vecs[12] = mk(0, 32'hFFFF_FF84, 32'h0,         MASK_RB,       1, 64'h0000_1234_CAFE_0001);
    vecs[13] = mk(0, 32'hFFFF_FF88, 32'h0,         32'h0,         1, 64'h0000_1234_CAFE_0001);
    vecs[14] = mk(0, 32'hFFFF_FF80, 32'h0,         32'h0,         1, 64'h0000_1234_CAFE_0001);

    resetn = 1'b0; we = 1'b0; addr = '0; wdata = '0; in_port = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset out_port", out_port, 64'h0);
    rd(32'hFFFF_FF80, 32'h0, "reset flags");
    resetn = 1'b1;
    tick(1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d io_hit", i), 64'(io_hit), 64'(vecs[i].exp_hit));
      check($sformatf("vec%0d out_port", i), out_port, vecs[i].exp_out);
    end
    @(negedge clock);
    we = 1'b0;

    // input synchroniser latency and change flag
    in_port[31:0] = 32'hA5A5_A5A5;
    rd(32'hFFFF_FF40, 32'h0, "in0 0 edges");
    tick(1);
    rd(32'hFFFF_FF40, 32'h0, "in0 1 edge");
    tick(1);
    rd(32'hFFFF_FF40, 32'hA5A5_A5A5, "in0 2 edges");
    rd(32'hFFFF_FF80, 32'h0, "flags 2 edges");
    tick(1);
    rd(32'hFFFF_FF80, 32'h1, "flags 3 edges");

    // W1C and set-beats-clear
    in_port[63:32] = 32'h1;
    tick(3);
    rd(32'hFFFF_FF80, 32'h3, "flags both");
    wr(32'hFFFF_FF80, 32'h1);
    tick(1);
    rd(32'hFFFF_FF80, 32'h2, "w1c bit0");
    in_port[31:0] = 32'h5A5A_5A5A;
    tick(2);
    wr(32'hFFFF_FF80, 32'h1);
    tick(1);
    rd(32'hFFFF_FF80, 32'h3, "set wins over clear");
    wr(32'hFFFF_FF80, 32'h3);
    tick(1);
    rd(32'hFFFF_FF80, 32'h0, "w1c all");

    // asynchronous reset in the middle of a store
    wr(32'hFFFF_FF00, 32'h1111);
    #2 resetn = 1'b0;
    #1;
    check("async rst out_port", out_port, 64'h0);
    rd(32'hFFFF_FF80, 32'h0, "async rst flags");
    rd(32'hFFFF_FF40, 32'h0, "async rst in0");
`ifdef SC_MMIO_IRQ_EN
    check("async rst irq", 64'(irq), 64'h0);
`endif
    tick(1);
    resetn = 1'b1;
    wr(32'hFFFF_FF00, 32'h2222);
    tick(1);
    we = 1'b0;
    check("post-rst store", out_port, 64'h0000_0000_0000_2222);
    tick(2);
    rd(32'hFFFF_FF80, 32'h3, "post-rst flags");
    rd(32'hFFFF_FF40, 32'h5A5A_5A5A, "post-rst in0");

`ifdef SC_MMIO_IRQ_EN
    wr(32'hFFFF_FF80, 32'h3);
    tick(1);
    wr(32'hFFFF_FF84, 32'h2);
    tick(1);
    we = 1'b0;
    check("irq idle", 64'(irq), 64'h0);
    in_port[63:32] = 32'h0;
    tick(3);
    rd(32'hFFFF_FF80, 32'h2, "irq flag set");
    check("irq 3 edges", 64'(irq), 64'h0);
    tick(1);
    check("irq 4 edges", 64'(irq), 64'h1);
    wr(32'hFFFF_FF80, 32'h2);
    tick(1);
    we = 1'b0;
    check("irq at w1c edge", 64'(irq), 64'h1);
    tick(1);
    check("irq after w1c", 64'(irq), 64'h0);
    in_port[31:0] = 32'h0;
    tick(5);
    check("irq masked in0", 64'(irq), 64'h0);
    rd(32'hFFFF_FF80, 32'h1, "masked flag set");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
